fpadd_sequencer: RTL and testbench

- Multi-cycle control FSM for the floating-point add/subtract datapath.
- Accepts one operation at a time and latches the effective operation (eop = op ^ a_sign ^ b_sign).
- Sequences the phases compare/swap, alignment, add, normalize, round, post-round fix and result load.
- Drives one-cycle control strobes into the mantissa/exponent datapath and reads back its status flags.

---
 rtl/fpadd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fpadd_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_sequencer.sv
// Control FSM for the multi-cycle floating-point add/subtract datapath.
// Optional macro FPADD_FAST_ALIGN_EN: single-cycle barrel alignment instead of 1-bit steps.
module fpadd_sequencer #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 24,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] exp_diff,
    input  logic             a_ge_b,
    input  logic             sum_zero,
    input  logic             sum_carry,
    input  logic             sum_msb,
    input  logic             exp_zero,
    input  logic             exp_max,
    output logic             in_ready,
    output logic             busy,
    output logic             ld_operands,
    output logic             swap,
    output logic             shr_small,
    output logic [CNT_W-1:0] shr_amt,
    output logic             ld_sum,
    output logic             eop,
    output logic             shr_sum,
    output logic             exp_inc,
    output logic             shl_sum,
    output logic             exp_dec,
    output logic             round_en,
    output logic             ld_result,
    output logic             force_pos_zero,
    output logic             done,
    output logic             overflow,
    output logic             underflow
);
    // Shifting further than the mantissa plus guard/round bits changes nothing.
    localparam int unsigned SatCnt = MAN_W + 2;

    typedef enum logic [2:0] {
        StIdle, StCmp, StAlign, StAdd, StNorm, StRound, StFin, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] norm_cnt_q, norm_cnt_d;
    logic             eop_q, eop_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             accept;

    assign in_ready    = (state_q == StIdle);
    assign busy        = ~in_ready;
    assign accept      = in_ready & start;
    assign ld_operands = accept;
    assign eop         = eop_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        norm_cnt_d     = norm_cnt_q;
        eop_d          = eop_q;
        zero_d         = zero_q;
        ovf_d          = ovf_q;
        unf_d          = unf_q;
        swap           = 1'b0;
        shr_small      = 1'b0;
        ld_sum         = 1'b0;
        shr_sum        = 1'b0;
        exp_inc        = 1'b0;
        shl_sum        = 1'b0;
        exp_dec        = 1'b0;
        round_en       = 1'b0;
        ld_result      = 1'b0;
        force_pos_zero = 1'b0;
        done           = 1'b0;
`ifdef FPADD_FAST_ALIGN_EN
        shr_amt        = cnt_q;
`else
        shr_amt        = CNT_W'(1);
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    eop_d   = op ^ a_sign ^ b_sign;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                swap = ~a_ge_b;
                if (32'(exp_diff) > SatCnt) begin
                    cnt_d = CNT_W'(SatCnt);
                end else begin
                    cnt_d = CNT_W'(exp_diff);
                end
                state_d = (cnt_d != '0) ? StAlign : StAdd;
            end
            StAlign: begin
                shr_small = 1'b1;
`ifdef FPADD_FAST_ALIGN_EN
                cnt_d     = '0;
                state_d   = StAdd;
`else
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StAdd;
                end
`endif
            end
            StAdd: begin
                ld_sum     = 1'b1;
                norm_cnt_d = '0;
                state_d    = StNorm;
            end
            StNorm: begin
                if (sum_zero) begin
                    zero_d  = 1'b1;
                    state_d = StRound;
                end else if (sum_carry) begin
                    shr_sum = 1'b1;
                    exp_inc = 1'b1;
                    state_d = StRound;
                end else if (!sum_msb && exp_zero) begin
                    unf_d   = 1'b1;
                    state_d = StRound;
                end else if (!sum_msb && (32'(norm_cnt_q) < MAN_W)) begin
                    shl_sum    = 1'b1;
                    exp_dec    = 1'b1;
                    norm_cnt_d = norm_cnt_q + CNT_W'(1);
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                round_en = ~zero_q;
                state_d  = StFin;
            end
            StFin: begin
                // Rounding may carry out of the mantissa; renormalize once.
                if (sum_carry) begin
                    shr_sum = 1'b1;
                    exp_inc = 1'b1;
                end
                state_d = StDone;
            end
            StDone: begin
                ld_result      = 1'b1;
                done           = 1'b1;
                force_pos_zero = zero_q;
                ovf_d          = exp_max & ~zero_q;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            norm_cnt_q <= '0;
            eop_q      <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            norm_cnt_q <= norm_cnt_d;
            eop_q      <= eop_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

endmodule

// File: tb/tb_fpadd_sequencer.sv
// Directed bench for fpadd_sequencer with a small behavioural datapath stub for status flags.
module tb_fpadd_sequencer;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 24;
    localparam int unsigned CNT_W = 6;
`ifdef FPADD_FAST_ALIGN_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif
    localparam int NS = 11;

    logic             clk, rst_n, start, op, a_sign, b_sign, a_ge_b;
    logic [EXP_W-1:0] exp_diff;
    logic             sum_zero, sum_carry, sum_msb, exp_zero, exp_max;
    logic             in_ready, busy, ld_operands, swap, shr_small, ld_sum, eop;
    logic [CNT_W-1:0] shr_amt;
    logic             shr_sum, exp_inc, shl_sum, exp_dec, round_en, ld_result;
    logic             force_pos_zero, done, overflow, underflow;

    fpadd_sequencer #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_sign(a_sign), .b_sign(b_sign),
        .exp_diff(exp_diff), .a_ge_b(a_ge_b), .sum_zero(sum_zero), .sum_carry(sum_carry),
        .sum_msb(sum_msb), .exp_zero(exp_zero), .exp_max(exp_max), .in_ready(in_ready),
        .busy(busy), .ld_operands(ld_operands), .swap(swap), .shr_small(shr_small),
        .shr_amt(shr_amt), .ld_sum(ld_sum), .eop(eop), .shr_sum(shr_sum), .exp_inc(exp_inc),
        .shl_sum(shl_sum), .exp_dec(exp_dec), .round_en(round_en), .ld_result(ld_result),
        .force_pos_zero(force_pos_zero), .done(done), .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stub: carry clears after a right shift, msb/exp_zero appear after N left shifts.
    logic cfg_zero, cfg_carry, cfg_emax;
    int   cfg_msb_after, cfg_ez_after;
    int   shl_cnt, shr_cnt;

    always @(posedge clk) begin
        if (ld_operands) begin
            shl_cnt <= 0;
            shr_cnt <= 0;
        end else begin
            if (shl_sum) shl_cnt <= shl_cnt + 1;
            if (shr_sum) shr_cnt <= shr_cnt + 1;
        end
    end

    assign sum_zero  = cfg_zero;
    assign sum_carry = cfg_carry && (shr_cnt == 0);
    assign sum_msb   = (shl_cnt >= cfg_msb_after);
    assign exp_zero  = (shl_cnt >= cfg_ez_after);
    assign exp_max   = cfg_emax;

    int checks, errors;
    // Per-strobe count and first cycle relative to accept; index order matches the sample vector.
    int n_st[NS];
    int f_st[NS];
    int t_done, max_amt, conflicts, fpz_at_done, eop_at_done;
    int ovf_at1, unf_at1, ovf_after, unf_after;

    task automatic check_eq(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic set_cfg(input logic z, input logic c, input int msb_after, input int ez_after,
                           input logic emax);
        cfg_zero      = z;
        cfg_carry     = c;
        cfg_msb_after = msb_after;
        cfg_ez_after  = ez_after;
        cfg_emax      = emax;
    endtask

    task automatic run_op(input logic op_v, input logic a_v, input logic b_v, input int ed,
                          input logic agb, input logic spam);
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) begin
            n_st[i] = 0;
            f_st[i] = -1;
        end
        t_done = -1; max_amt = 0; conflicts = 0; fpz_at_done = -1; eop_at_done = -1;
        ovf_at1 = -1; unf_at1 = -1;
        @(posedge clk); #1;
        start = 1'b1; op = op_v; a_sign = a_v; b_sign = b_v;
        exp_diff = EXP_W'(ed); a_ge_b = agb;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            v = {done, ld_result, round_en, exp_dec, shl_sum, exp_inc, shr_sum, ld_sum,
                 shr_small, swap, ld_operands};
            for (int i = 0; i < NS; i++) begin
                if (v[i]) begin
                    n_st[i]++;
                    if (f_st[i] < 0) f_st[i] = k;
                end
            end
            if (shr_small && int'(shr_amt) > max_amt) max_amt = int'(shr_amt);
            if ((shr_sum && shl_sum) || (exp_inc && exp_dec) || (shr_sum && exp_dec) ||
                (shl_sum && exp_inc)) conflicts++;
            if (k == 1) begin
                ovf_at1 = int'(overflow);
                unf_at1 = int'(underflow);
            end
            if (done) begin
                t_done      = k;
                fpz_at_done = int'(force_pos_zero);
                eop_at_done = int'(eop);
                break;
            end
            @(posedge clk); #1;
            start = spam;
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        ovf_after = int'(overflow);
        unf_after = int'(underflow);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a_sign = 1'b0; b_sign = 1'b0;
        exp_diff = '0; a_ge_b = 1'b1;
        set_cfg(1'b0, 1'b0, 0, 99, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_flags", int'({overflow, underflow, eop}), 0);
        rst_n = 1'b1;

        // Carry out of the add: one right shift, no normalization loop.
        set_cfg(1'b0, 1'b1, 0, 99, 1'b0);
        run_op(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        check_eq("carry_ld_operands_t", f_st[0], 0);
        check_eq("carry_ld_sum_t", f_st[3], 2);
        check_eq("carry_shr_sum_t", f_st[4], 3);
        check_eq("carry_exp_inc_t", f_st[5], 3);
        check_eq("carry_shr_sum_n", n_st[4], 1);
        check_eq("carry_round_en_t", f_st[8], 4);
        check_eq("carry_ld_result_t", f_st[9], 6);
        check_eq("carry_done_t", t_done, 6);
        check_eq("carry_eop", eop_at_done, 0);
        check_eq("carry_fpz", fpz_at_done, 0);
        check_eq("carry_swap_n", n_st[1], 0);
        check_eq("carry_conflicts", conflicts, 0);

        // Reset asserted mid-alignment.
        set_cfg(1'b0, 1'b0, 0, 99, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a_sign = 1'b0; b_sign = 1'b0; exp_diff = 8'd10; a_ge_b = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_align_shr_small", int'(shr_small), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_strobes", int'({done, ld_result, round_en, exp_dec, shl_sum, exp_inc,
                                         shr_sum, ld_sum, shr_small, swap, ld_operands}), 0);
        check_eq("rstmid_in_ready", int'(in_ready), 1);
        check_eq("rstmid_busy", int'(busy), 0);
        @(posedge clk); #1;
        check_eq("rstmid_done_held", int'(done), 0);
        rst_n = 1'b1;
        run_op(1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        check_eq("rstmid_fresh_done_t", t_done, Fast ? 7 : 16);

        // Swap plus 3-step align, start spammed while busy.
        run_op(1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1);
        check_eq("swap_t", f_st[1], 1);
        check_eq("swap_n", n_st[1], 1);
        check_eq("align_shr_small_t", f_st[2], 2);
        check_eq("align_shr_small_n", n_st[2], Fast ? 1 : 3);
        check_eq("align_ld_sum_t", f_st[3], Fast ? 3 : 5);
        check_eq("align_done_t", t_done, Fast ? 7 : 9);
        check_eq("align_ld_operands_n", n_st[0], 1);

        // Alignment count saturates at MAN_W+2.
        run_op(1'b0, 1'b0, 1'b1, 200, 1'b1, 1'b0);
        check_eq("sat_shr_small_n", n_st[2], Fast ? 1 : 26);
        check_eq("sat_shr_amt", max_amt, Fast ? 26 : 1);
        check_eq("sat_done_t", t_done, Fast ? 7 : 32);
        check_eq("sat_eop", eop_at_done, 1);

        // Exact cancellation gives +0; exp_max must not raise overflow for zero.
        set_cfg(1'b1, 1'b0, 0, 99, 1'b1);
        run_op(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        check_eq("zero_eop", eop_at_done, 1);
        check_eq("zero_shift_n", n_st[4] + n_st[6] + n_st[5] + n_st[7], 0);
        check_eq("zero_round_en_n", n_st[8], 0);
        check_eq("zero_fpz", fpz_at_done, 1);
        check_eq("zero_done_t", t_done, 6);
        check_eq("zero_ovf", ovf_after, 0);

        // Four left shifts to normalize.
        set_cfg(1'b0, 1'b0, 4, 99, 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        check_eq("norm_shl_n", n_st[6], 4);
        check_eq("norm_exp_dec_n", n_st[7], 4);
        check_eq("norm_done_t", t_done, 10);
        check_eq("norm_unf", unf_after, 0);
        check_eq("norm_conflicts", conflicts, 0);

        // Exponent bottoms out after two shifts.
        set_cfg(1'b0, 1'b0, 99, 2, 1'b0);
        run_op(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        check_eq("unf_shl_n", n_st[6], 2);
        check_eq("unf_flag", unf_after, 1);
        check_eq("unf_done_t", t_done, 8);

        // Carry into the maximum exponent; underflow from before clears on accept.
        set_cfg(1'b0, 1'b1, 0, 99, 1'b1);
        run_op(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        check_eq("ovf_unf_cleared", unf_at1, 0);
        check_eq("ovf_flag", ovf_after, 1);
        check_eq("ovf_done_t", t_done, 6);
        @(negedge clk);
        check_eq("ovf_sticky", int'(overflow), 1);

        set_cfg(1'b0, 1'b0, 0, 99, 1'b0);
        run_op(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        check_eq("ovf_cleared", ovf_at1, 0);
        check_eq("plain_done_t", t_done, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
